// File: rtl/rho_step_seq.sv
// rho_step_seq: multi-cycle Keccak rho step for lane widths 8..64 bits.
// The 5x5 state is loaded into a working register. A fixed group of lanes is
// then rotated in place on each beat, and the finished state is held for the
// consumer. Forward mode rotates left; inverse mode rotates right by the same
// amount, so inverse(forward(s)) == s.
module rho_step_seq #(
  parameter int LANE_W          = 64,
  parameter int LANES_PER_CYCLE = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_inverse,
  input  logic [4:0][4:0][LANE_W-1:0]     state_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [4:0][4:0][LANE_W-1:0]     state_out,
  output logic                            busy
);

  localparam int NUM_BEATS = 25 / LANES_PER_CYCLE;
  localparam int BEAT_W    = 5;

  // FIPS 202 rho offsets, indexed by linear lane index 5*y + x.
  function automatic int rhoOffset(input int idx);
    case (idx)
      0:  return 0;   1:  return 1;   2:  return 62;  3:  return 28;  4:  return 27;
      5:  return 36;  6:  return 44;  7:  return 6;   8:  return 55;  9:  return 20;
      10: return 3;   11: return 10;  12: return 43;  13: return 25;  14: return 39;
      15: return 41;  16: return 45;  17: return 15;  18: return 21;  19: return 8;
      20: return 18;  21: return 2;   22: return 61;  23: return 56;  24: return 14;
      default: return 0;
    endcase
  endfunction

  if (!(LANE_W == 8 || LANE_W == 16 || LANE_W == 32 || LANE_W == 64)) begin : g_badLaneW
    $fatal(1, "rho_step_seq: LANE_W must be 8, 16, 32 or 64");
  end
  if (!(LANES_PER_CYCLE == 1 || LANES_PER_CYCLE == 5 || LANES_PER_CYCLE == 25)) begin : g_badLpc
    $fatal(1, "rho_step_seq: LANES_PER_CYCLE must be 1, 5 or 25");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                        r_fsm;
  logic [4:0][4:0][LANE_W-1:0]   r_state;
  logic                          r_inverse;
  logic [BEAT_W-1:0]             r_beat;
  logic                          r_inReady;
  logic                          r_outValid;
  logic                          r_busy;

  logic [LANE_W-1:0]             w_rotated [25];
  logic [24:0]                   w_inBeat;

  // Each lane has a fixed rotation amount, so its rotator is pure wiring plus a
  // direction mux. The beat counter selects which lanes take their new value.
  for (genvar i = 0; i < 25; i++) begin : g_lane
    localparam int X   = i % 5;
    localparam int Y   = i / 5;
    localparam int AMT = rhoOffset(i) % LANE_W;
    localparam int REV = (LANE_W - AMT) % LANE_W;
    logic [LANE_W-1:0] w_lane;
    logic [LANE_W-1:0] w_rotl;
    logic [LANE_W-1:0] w_rotr;
    assign w_lane       = r_state[X][Y];
    assign w_rotl       = (w_lane << AMT) | (w_lane >> REV);
    assign w_rotr       = (w_lane >> AMT) | (w_lane << REV);
    assign w_rotated[i] = r_inverse ? w_rotr : w_rotl;
    assign w_inBeat[i]  = (r_beat == BEAT_W'(i / LANES_PER_CYCLE));
  end

  // Control FSM and working register. BUSY runs NUM_BEATS rotating beats and
  // then one wrap-up cycle at counter value NUM_BEATS that raises out_valid.
  // The result stays in r_state while out_valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm      <= IDLE;
      r_state    <= '0;
      r_inverse  <= 1'b0;
      r_beat     <= '0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_state   <= state_in;
            r_inverse <= in_inverse;
            r_beat    <= '0;
            r_fsm     <= BUSY;
            r_inReady <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        BUSY: begin
          for (int i = 0; i < 25; i++) begin
            if (w_inBeat[i]) begin
              r_state[i % 5][i / 5] <= w_rotated[i];
            end
          end
          if (r_beat == BEAT_W'(NUM_BEATS)) begin
            r_fsm      <= DONE;
            r_outValid <= 1'b1;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_fsm      <= IDLE;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        default: begin
          r_fsm <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign busy      = r_busy;
  assign state_out = r_state;

endmodule

// File: tb/tb_rho_step_seq.sv
// tb_rho_step_seq: exercises five rho_step_seq configurations that cover every
// lane width and every lanes-per-cycle value. It compares results against a
// bit-level rotation model built from the FIPS 202 offset table.
module tb_rho_step_seq;

  typedef logic [63:0] lanes_t [25];

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  inValid;
  logic [4:0]  inInverse;
  logic [4:0]  outReady;
  wire  [4:0]  inReady;
  wire  [4:0]  outValid;
  wire  [4:0]  busyW;

  logic [4:0][4:0][63:0] sIn0, sIn1;
  wire  [4:0][4:0][63:0] sOut0, sOut1;
  logic [4:0][4:0][7:0]  sIn2;
  wire  [4:0][4:0][7:0]  sOut2;
  logic [4:0][4:0][15:0] sIn3;
  wire  [4:0][4:0][15:0] sOut3;
  logic [4:0][4:0][31:0] sIn4;
  wire  [4:0][4:0][31:0] sOut4;

  int nChecks = 0;
  int nPassed = 0;

  int rhoTable [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                        41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  rho_step_seq #(.LANE_W(64), .LANES_PER_CYCLE(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .in_inverse(inInverse[0]), .state_in(sIn0), .out_valid(outValid[0]),
    .out_ready(outReady[0]), .state_out(sOut0), .busy(busyW[0]));
  rho_step_seq #(.LANE_W(64), .LANES_PER_CYCLE(5)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .in_inverse(inInverse[1]), .state_in(sIn1), .out_valid(outValid[1]),
    .out_ready(outReady[1]), .state_out(sOut1), .busy(busyW[1]));
  rho_step_seq #(.LANE_W(8), .LANES_PER_CYCLE(25)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[2]), .in_ready(inReady[2]),
    .in_inverse(inInverse[2]), .state_in(sIn2), .out_valid(outValid[2]),
    .out_ready(outReady[2]), .state_out(sOut2), .busy(busyW[2]));
  rho_step_seq #(.LANE_W(16), .LANES_PER_CYCLE(5)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[3]), .in_ready(inReady[3]),
    .in_inverse(inInverse[3]), .state_in(sIn3), .out_valid(outValid[3]),
    .out_ready(outReady[3]), .state_out(sOut3), .busy(busyW[3]));
  rho_step_seq #(.LANE_W(32), .LANES_PER_CYCLE(1)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[4]), .in_ready(inReady[4]),
    .in_inverse(inInverse[4]), .state_in(sIn4), .out_valid(outValid[4]),
    .out_ready(outReady[4]), .state_out(sOut4), .busy(busyW[4]));

  function automatic int cfgW(input int c);
    case (c)
      0: return 64;
      1: return 64;
      2: return 8;
      3: return 16;
      default: return 32;
    endcase
  endfunction

  function automatic int cfgBeats(input int c);
    case (c)
      0: return 25;
      1: return 5;
      2: return 1;
      3: return 5;
      default: return 25;
    endcase
  endfunction

  function automatic logic [63:0] laneMask(input int w);
    if (w == 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  // Returns index of first differing lane, or -1 when identical.
  function automatic int firstDiff(input lanes_t a, input lanes_t b);
    for (int i = 0; i < 25; i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  task automatic randLanes(input int c, output lanes_t s);
    for (int i = 0; i < 25; i++) s[i] = {$urandom, $urandom} & laneMask(cfgW(c));
  endtask

  // Reference model: move each bit to its rotated position.
  task automatic refState(input lanes_t s, input int w, input bit inv, output lanes_t o);
    for (int i = 0; i < 25; i++) begin
      int n;
      n = rhoTable[i] % w;
      if (inv) n = (w - n) % w;
      o[i] = '0;
      for (int b = 0; b < w; b++) o[i][(b + n) % w] = s[i][b];
    end
  endtask

  task automatic driveState(input int c, input lanes_t s);
    for (int i = 0; i < 25; i++) begin
      case (c)
        0: sIn0[i % 5][i / 5] = s[i];
        1: sIn1[i % 5][i / 5] = s[i];
        2: sIn2[i % 5][i / 5] = s[i][7:0];
        3: sIn3[i % 5][i / 5] = s[i][15:0];
        default: sIn4[i % 5][i / 5] = s[i][31:0];
      endcase
    end
  endtask

  task automatic readOut(input int c, output lanes_t o);
    for (int i = 0; i < 25; i++) begin
      case (c)
        0: o[i] = sOut0[i % 5][i / 5];
        1: o[i] = sOut1[i % 5][i / 5];
        2: o[i] = 64'(sOut2[i % 5][i / 5]);
        3: o[i] = 64'(sOut3[i % 5][i / 5]);
        default: o[i] = 64'(sOut4[i % 5][i / 5]);
      endcase
    end
  endtask

  // Full transaction on config c. After the accept edge the inputs are
  // scrambled, which must not affect the result. lat counts clock edges from
  // the accept edge until out_valid is seen (200 means timeout).
  task automatic applyStimulus(input int c, input lanes_t s, input bit inv,
                               output lanes_t res, output int lat);
    lanes_t junk;
    @(negedge clk);
    driveState(c, s);
    inInverse[c] = inv;
    inValid[c] = 1'b1;
    @(negedge clk);
    inValid[c] = 1'b0;
    inInverse[c] = ~inv;
    randLanes(c, junk);
    driveState(c, junk);
    lat = 0;
    while (outValid[c] !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    readOut(c, res);
    outReady[c] = 1'b1;
    @(negedge clk);
    outReady[c] = 1'b0;
  endtask

  task automatic test_reset();
    lanes_t o;
    nChecks++;
    if (inReady !== 5'b11111) $display("[TB] FAIL reset_in_ready: got %b expected 11111", inReady);
    else nPassed++;
    nChecks++;
    if (outValid !== 5'b00000) $display("[TB] FAIL reset_out_valid: got %b expected 00000", outValid);
    else nPassed++;
    nChecks++;
    if (busyW !== 5'b00000) $display("[TB] FAIL reset_busy: got %b expected 00000", busyW);
    else nPassed++;
    for (int c = 0; c < 5; c++) begin
      int nz;
      readOut(c, o);
      nz = -1;
      for (int i = 0; i < 25; i++) if (o[i] !== 64'd0) nz = i;
      nChecks++;
      if (nz != -1) $display("[TB] FAIL reset_state_out cfg%0d: lane %0d got %h expected 0", c, nz, o[nz]);
      else nPassed++;
    end
  endtask

  task automatic test_single_lane();
    lanes_t s, res, exp;
    int lat, d;
    for (int i = 0; i < 25; i++) begin
      s[i] = '0;
      exp[i] = '0;
    end
    s[1] = 64'h1;
    exp[1] = 64'h2;
    applyStimulus(0, s, 1'b0, res, lat);
    nChecks++;
    if (lat != 26) $display("[TB] FAIL single_latency: got %0d expected 26", lat);
    else nPassed++;
    d = firstDiff(res, exp);
    nChecks++;
    if (d != -1) $display("[TB] FAIL single_lane lane%0d: got %h expected %h", d, res[d], exp[d]);
    else nPassed++;
  endtask

  task automatic test_lpc5_ones();
    lanes_t s, res, exp;
    int lat, d;
    for (int i = 0; i < 25; i++) s[i] = 64'h1;
    applyStimulus(1, s, 1'b0, res, lat);
    nChecks++;
    if (lat != 6) $display("[TB] FAIL lpc5_latency: got %0d expected 6", lat);
    else nPassed++;
    nChecks++;
    if (res[2] !== 64'h4000000000000000) $display("[TB] FAIL lpc5_x2y0: got %h expected 4000000000000000", res[2]);
    else nPassed++;
    nChecks++;
    if (res[3] !== 64'h0000000010000000) $display("[TB] FAIL lpc5_x3y0: got %h expected 0000000010000000", res[3]);
    else nPassed++;
    nChecks++;
    if (res[5] !== 64'h0000001000000000) $display("[TB] FAIL lpc5_x0y1: got %h expected 0000001000000000", res[5]);
    else nPassed++;
    nChecks++;
    if (res[0] !== 64'h1) $display("[TB] FAIL lpc5_x0y0: got %h expected 1", res[0]);
    else nPassed++;
    nChecks++;
    if (res[24] !== 64'h4000) $display("[TB] FAIL lpc5_x4y4: got %h expected 4000", res[24]);
    else nPassed++;
    refState(s, 64, 1'b0, exp);
    d = firstDiff(res, exp);
    nChecks++;
    if (d != -1) $display("[TB] FAIL lpc5_model lane%0d: got %h expected %h", d, res[d], exp[d]);
    else nPassed++;
  endtask

  task automatic test_w8_lpc25();
    lanes_t s, res, back;
    int lat, d;
    for (int i = 0; i < 25; i++) s[i] = 64'h01;
    applyStimulus(2, s, 1'b0, res, lat);
    nChecks++;
    if (lat != 2) $display("[TB] FAIL w8_latency: got %0d expected 2", lat);
    else nPassed++;
    nChecks++;
    if (res[2] !== 64'h40) $display("[TB] FAIL w8_x2y0: got %h expected 40", res[2]);
    else nPassed++;
    nChecks++;
    if (res[3] !== 64'h10) $display("[TB] FAIL w8_x3y0: got %h expected 10", res[3]);
    else nPassed++;
    nChecks++;
    if (res[24] !== 64'h40) $display("[TB] FAIL w8_x4y4: got %h expected 40", res[24]);
    else nPassed++;
    applyStimulus(2, res, 1'b1, back, lat);
    d = firstDiff(back, s);
    nChecks++;
    if (d != -1) $display("[TB] FAIL w8_inverse lane%0d: got %h expected %h", d, back[d], s[d]);
    else nPassed++;
  endtask

  task automatic test_round_trip();
    lanes_t s, fwd, back, exp;
    int latF, latB, d;
    for (int c = 0; c < 5; c++) begin
      for (int n = 0; n < 100; n++) begin
        randLanes(c, s);
        applyStimulus(c, s, 1'b0, fwd, latF);
        applyStimulus(c, fwd, 1'b1, back, latB);
        refState(s, cfgW(c), 1'b0, exp);
        d = firstDiff(fwd, exp);
        nChecks++;
        if (d != -1 || latF != cfgBeats(c) + 1 || latB != cfgBeats(c) + 1)
          $display("[TB] FAIL round_fwd cfg%0d iter%0d: lane %0d got %h expected %h, latency %0d/%0d expected %0d",
                   c, n, d, (d < 0) ? 64'd0 : fwd[d], (d < 0) ? 64'd0 : exp[d], latF, latB, cfgBeats(c) + 1);
        else nPassed++;
        d = firstDiff(back, s);
        nChecks++;
        if (d != -1) $display("[TB] FAIL round_trip cfg%0d iter%0d lane%0d: got %h expected %h",
                              c, n, d, back[d], s[d]);
        else nPassed++;
      end
    end
  endtask

  task automatic test_backpressure();
    lanes_t s, exp, o, junk;
    int wait_n, d;
    randLanes(0, s);
    refState(s, 64, 1'b0, exp);
    @(negedge clk);
    driveState(0, s);
    inInverse[0] = 1'b0;
    inValid[0] = 1'b1;
    @(negedge clk);
    inValid[0] = 1'b0;
    wait_n = 0;
    while (outValid[0] !== 1'b1 && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    nChecks++;
    if (wait_n != 26) $display("[TB] FAIL bp_latency: got %0d expected 26", wait_n);
    else nPassed++;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      readOut(0, o);
      d = firstDiff(o, exp);
      nChecks++;
      if (outValid[0] !== 1'b1 || inReady[0] !== 1'b0 || busyW[0] !== 1'b1 || d != -1)
        $display("[TB] FAIL bp_hold cycle%0d: out_valid=%b in_ready=%b busy=%b diff_lane=%0d, expected 1 0 1 -1",
                 k, outValid[0], inReady[0], busyW[0], d);
      else nPassed++;
      randLanes(0, junk);
      driveState(0, junk);
      inValid[0] = k[0];
    end
    inValid[0] = 1'b0;
    outReady[0] = 1'b1;
    @(negedge clk);
    outReady[0] = 1'b0;
    nChecks++;
    if (inReady[0] !== 1'b1 || outValid[0] !== 1'b0 || busyW[0] !== 1'b0)
      $display("[TB] FAIL bp_release: in_ready=%b out_valid=%b busy=%b expected 1 0 0",
               inReady[0], outValid[0], busyW[0]);
    else nPassed++;
    @(negedge clk);
    nChecks++;
    if (busyW[0] !== 1'b0) $display("[TB] FAIL bp_ignored_input: busy got %b expected 0", busyW[0]);
    else nPassed++;
  endtask

  task automatic test_reset_mid_busy();
    lanes_t s, o, res, exp;
    int lat, d, nz;
    randLanes(0, s);
    @(negedge clk);
    driveState(0, s);
    inInverse[0] = 1'b0;
    inValid[0] = 1'b1;
    @(negedge clk);
    inValid[0] = 1'b0;
    repeat (12) @(negedge clk);
    nChecks++;
    if (busyW[0] !== 1'b1) $display("[TB] FAIL mid_busy_pre: busy got %b expected 1", busyW[0]);
    else nPassed++;
    #2 rst_n = 1'b0;
    #1;
    readOut(0, o);
    nz = -1;
    for (int i = 0; i < 25; i++) if (o[i] !== 64'd0) nz = i;
    nChecks++;
    if (inReady[0] !== 1'b1 || outValid[0] !== 1'b0 || busyW[0] !== 1'b0 || nz != -1)
      $display("[TB] FAIL mid_busy_reset: in_ready=%b out_valid=%b busy=%b nonzero_lane=%0d expected 1 0 0 -1",
               inReady[0], outValid[0], busyW[0], nz);
    else nPassed++;
    @(negedge clk);
    rst_n = 1'b1;
    randLanes(0, s);
    refState(s, 64, 1'b0, exp);
    applyStimulus(0, s, 1'b0, res, lat);
    d = firstDiff(res, exp);
    nChecks++;
    if (lat != 26 || d != -1)
      $display("[TB] FAIL mid_busy_after: latency %0d expected 26, diff_lane %0d expected -1", lat, d);
    else nPassed++;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    rst_n = 1'b0;
    inValid = '0;
    inInverse = '0;
    outReady = '0;
    sIn0 = '0;
    sIn1 = '0;
    sIn2 = '0;
    sIn3 = '0;
    sIn4 = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_single_lane();
    test_lpc5_ones();
    test_w8_lpc25();
    test_backpressure();
    test_reset_mid_busy();
    test_round_trip();
    $display("[TB] %0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule

// File: doc/rho_step_seq.md
Name: rho_step_seq

Overview:
- Parametrised, sequential successor of the combinational Keccak rho step.
- Applies the FIPS 202 rho lane rotations to a full 5x5 state for any lane width W in {8,16,32,64}, i.e. Keccak-f[200..1600].
- Processes LANES_PER_CYCLE lanes per clock, trading area for latency.
- Supports forward rho and inverse rho (rotate right) for permutation/inverse-permutation datapaths, with valid/ready handshakes on both sides.

Parameters:
- LANE_W, 64, lane width w in bits; legal values 8, 16, 32, 64.
- LANES_PER_CYCLE, 1, lanes rotated per beat; legal values 1, 5, 25.
- NUM_BEATS, 25/LANES_PER_CYCLE, derived localparam; not overridable.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input state valid.
- in_ready  output  1  block can accept a state.
- in_inverse  input  1  sampled with the state: 0 = rho (rotate left), 1 = inverse rho (rotate right).
- state_in  input  [4:0][4:0][LANE_W-1:0]  state, indexed [x][y].
- out_valid  output  1  result state valid.
- out_ready  input  1  downstream accepts the result.
- state_out  output  [4:0][4:0][LANE_W-1:0]  rotated state, indexed [x][y].
- busy  output  1  high in BUSY and DONE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Offsets r[x][y], FIPS 202:
  - y=0: 0, 1, 62, 28, 27
  - y=1: 36, 44, 6, 55, 20
  - y=2: 3, 10, 43, 25, 39
  - y=3: 41, 45, 15, 21, 8
  - y=4: 18, 2, 61, 56, 14
- Effective rotation is r mod LANE_W, computed at elaboration. Forward: out = ROTL(lane, r mod w). Inverse: ROTR by the same amount.
- Lane processing order: linear index i = 5*y + x. Beat k processes i = k*LANES_PER_CYCLE to (k+1)*LANES_PER_CYCLE-1.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid: capture state_in and in_inverse into the working register, clear beat counter, go to BUSY.
  - BUSY: each cycle rotate the lanes of the current beat in place and increment the counter. After beat NUM_BEATS-1, go to DONE.
  - DONE: out_valid=1 and state_out = working register, held stable while out_ready=0. On out_ready=1, go to IDLE.
- Latency: accept edge to out_valid is NUM_BEATS+1 cycles (26, 6, 2 for LPC = 1, 5, 25).
- No back-to-back overlap: in_ready=0 in BUSY and DONE. Inputs presented then are ignored and not captured.
- in_inverse and state_in changes after the accept edge have no effect on the in-flight result.
- Reset values: in_ready=1, out_valid=0, busy=0, state_out=0, counter=0, FSM=IDLE.
- rst_n asserted mid-operation, in BUSY or DONE: the result is discarded and all outputs return to reset values immediately.
- Unbuffered: state_out may only change when out_valid is low.
- Illegal LANE_W or LANES_PER_CYCLE: $fatal at elaboration.

Test Plan:
- LANE_W=64, LPC=1, state_in[1][0]=0x1, rest 0, forward -> after 26 cycles out_valid=1; state_out[1][0]=0x2, all other lanes 0.
- LANE_W=64, LPC=5, all lanes 0x1, forward -> out_valid at cycle 6:
  - [2][0]=0x4000000000000000, [3][0]=0x0000000010000000, [0][1]=0x0000001000000000, [0][0]=0x1, [4][4]=0x4000.
- LANE_W=8, LPC=25, all lanes 0x01, forward -> out_valid at cycle 2; [2][0]=0x40 (62 mod 8 = 6), [3][0]=0x10, [4][4]=0x40. Inverse mode on that output restores all 0x01.
- Round trip: random 1600-bit state, forward then inverse -> identical to the original; repeat for 100 random states at each LANE_W.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and state_out stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle with in_ready=1.
- Reset mid-BUSY at beat 12 (LPC=1) -> out_valid=0, in_ready=1, state_out=0 asynchronously. A new transaction after release completes correctly in 26 cycles.
